// File: rtl/fp_int_to_fp_seq.sv
// rtl/fp_int_to_fp_seq.sv - sequential integer to single/double FP converter
// Normalises one bit per cycle, then rounds once according to in_rm.
module fp_int_to_fp_seq #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_signed,
  input  logic                  in_long,
  input  logic                  in_fmt,
  input  logic [2:0]            in_rm,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_busy,
  output logic                  out_flag_NX
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] mag;
  logic [5:0]  cnt;
  logic        sign;
  logic        fmt_r;
  logic [2:0]  rm_r;

  logic        accept;
  logic [63:0] src;
  logic        src_sign;
  logic [63:0] src_mag;
  logic        src_zero;

  assign accept   = in_valid && (state == IDLE || state == DONE);
  assign src      = in_long ? in_data :
                    (in_signed ? {{32{in_data[31]}}, in_data[31:0]} : {32'b0, in_data[31:0]});
  assign src_sign = in_signed & src[63];
  assign src_mag  = src_sign ? (~src + 64'd1) : src;
  assign src_zero = (src_mag == 64'd0);

  // Rounding datapath, evaluated from the normalised magnitude in ROUND
  logic        guard, sticky, lsb, round_up;
  logic [52:0] mant_d_sum;
  logic [23:0] mant_s_sum;
  logic [10:0] exp_d;
  logic [7:0]  exp_s;
  logic [63:0] result;

  always_comb begin
    guard  = fmt_r ? mag[10] : mag[39];
    sticky = fmt_r ? (|mag[9:0]) : (|mag[38:0]);
    lsb    = fmt_r ? mag[11] : mag[40];
    case (rm_r)
      3'b001:  round_up = 1'b0;
      3'b010:  round_up = sign & (guard | sticky);
      3'b011:  round_up = ~sign & (guard | sticky);
      3'b100:  round_up = guard;
      default: round_up = guard & (sticky | lsb);
    endcase
    mant_d_sum = {1'b0, mag[62:11]} + {52'b0, round_up};
    mant_s_sum = {1'b0, mag[62:40]} + {23'b0, round_up};
    exp_d = 11'd63 - {5'b0, cnt} + 11'd1023 + {10'b0, mant_d_sum[52]};
    exp_s = 8'd63 - {2'b0, cnt} + 8'd127 + {7'b0, mant_s_sum[23]};
    if (fmt_r)
      result = {sign, exp_d, mant_d_sum[51:0]};
    else
      result = {32'hFFFF_FFFF, sign, exp_s, mant_s_sum[22:0]};
  end

  always_ff @(posedge in_clk) begin
    if (in_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = src_zero ? DONE : NORM;
    end else begin
      case (state)
        NORM:    if (mag[63]) state_nxt = ROUND;
        ROUND:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_data    <= '0;
      out_flag_NX <= 1'b0;
      mag         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      fmt_r       <= 1'b0;
      rm_r        <= '0;
    end else if (accept) begin
      mag   <= src_mag;
      cnt   <= '0;
      sign  <= src_sign;
      fmt_r <= in_fmt;
      rm_r  <= in_rm;
      // Zero bypasses normalisation; single +0.0 is still NaN-boxed
      if (src_zero) begin
        out_data    <= in_fmt ? 64'd0 : {32'hFFFF_FFFF, 32'd0};
        out_flag_NX <= 1'b0;
      end
    end else if (state == NORM && !mag[63]) begin
      mag <= mag << 1;
      cnt <= cnt + 6'd1;
    end else if (state == ROUND) begin
      out_data    <= result;
      out_flag_NX <= guard | sticky;
    end
  end

  assign out_valid = (state == DONE);
  assign out_busy  = (state == NORM) || (state == ROUND);

endmodule

// File: tb/tb_fp_int_to_fp_seq.sv
// tb/tb_fp_int_to_fp_seq.sv - directed-vector bench for fp_int_to_fp_seq
module tb_fp_int_to_fp_seq;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_signed;
  logic        in_long;
  logic        in_fmt;
  logic [2:0]  in_rm;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_busy;
  logic        out_flag_NX;

  int n_cmp = 0;
  int n_bad = 0;

  fp_int_to_fp_seq #(.DATA_WIDTH(64)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_data(in_data),
    .in_signed(in_signed), .in_long(in_long), .in_fmt(in_fmt), .in_rm(in_rm),
    .out_data(out_data), .out_valid(out_valid), .out_busy(out_busy),
    .out_flag_NX(out_flag_NX)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request at the current negedge; returns just after the accepting edge
  task automatic issue(input logic [63:0] d, input logic s, input logic l,
                       input logic f, input logic [2:0] rm);
    in_data = d; in_signed = s; in_long = l; in_fmt = f; in_rm = rm;
    in_valid = 1'b1;
    @(posedge in_clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts edges from the accepting edge (inclusive) to out_valid high
  task automatic wait_done(input string tag, output int lat);
    bit ok = 0;
    lat = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge in_clk);
      if (out_valid) begin ok = 1; break; end
      @(posedge in_clk);
      lat++;
    end
    if (!ok) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run(input string tag, input logic [63:0] d, input logic s, input logic l,
                     input logic f, input logic [2:0] rm, input logic [63:0] exp_d,
                     input logic exp_nx, input int exp_lat);
    int lat;
    issue(d, s, l, f, rm);
    wait_done(tag, lat);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_nx"}, {63'd0, out_flag_NX}, {63'd0, exp_nx});
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    @(negedge in_clk);
    chk({tag, "_pulse"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_hold"}, out_data, exp_d);
  endtask

  initial begin
    int lat;
    int spurious;
    in_rst = 1'b1; in_valid = 1'b0; in_data = '0;
    in_signed = 1'b0; in_long = 1'b0; in_fmt = 1'b0; in_rm = 3'b000;
    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    chk("rst_data",  out_data, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",  {63'd0, out_busy}, 64'd0);
    chk("rst_nx",    {63'd0, out_flag_NX}, 64'd0);
    in_rst = 1'b0;
    @(negedge in_clk);

    run("d_m1",      64'h0000_0000_FFFF_FFFF, 1, 0, 1, 3'b000, 64'hBFF0_0000_0000_0000, 0, 66);
    run("d_min64",   64'h8000_0000_0000_0000, 1, 1, 1, 3'b000, 64'hC3E0_0000_0000_0000, 0, 3);
    run("s_max_rne", 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 3'b000, 64'hFFFF_FFFF_5F80_0000, 1, 3);
    run("s_max_rtz", 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 3'b001, 64'hFFFF_FFFF_5F7F_FFFF, 1, 3);
    run("s_tie_rne", 64'h0000_0000_0100_0001, 1, 0, 0, 3'b000, 64'hFFFF_FFFF_4B80_0000, 1, 42);
    run("s_tie_rup", 64'h0000_0000_0100_0001, 1, 0, 0, 3'b011, 64'hFFFF_FFFF_4B80_0001, 1, -1);
    run("s_tie_rdn", 64'h0000_0000_0100_0001, 1, 0, 0, 3'b010, 64'hFFFF_FFFF_4B80_0000, 1, -1);
    run("s_tie_rmm", 64'h0000_0000_0100_0001, 1, 0, 0, 3'b100, 64'hFFFF_FFFF_4B80_0001, 1, -1);
    run("s_tie_rm7", 64'h0000_0000_0100_0001, 1, 0, 0, 3'b111, 64'hFFFF_FFFF_4B80_0000, 1, -1);
    run("s_neg_rdn", 64'h1234_5678_FEFF_FFFF, 1, 0, 0, 3'b010, 64'hFFFF_FFFF_CB80_0001, 1, -1);
    run("s_neg_rup", 64'h0000_0000_FEFF_FFFF, 1, 0, 0, 3'b011, 64'hFFFF_FFFF_CB80_0000, 1, -1);
    run("s_m3",      64'h0000_0000_FFFF_FFFD, 1, 0, 0, 3'b000, 64'hFFFF_FFFF_C040_0000, 0, 65);
    run("s_zero",    64'hFFFF_FFFF_0000_0000, 0, 0, 0, 3'b000, 64'hFFFF_FFFF_0000_0000, 0, 1);

    // Zero, then a back-to-back request in DONE with an ignored pulse during NORM
    issue(64'd0, 1, 1, 1, 3'b000);
    wait_done("d_zero", lat);
    chk("d_zero_data", out_data, 64'd0);
    chk("d_zero_lat", 64'(lat), 64'd1);
    issue(64'd5, 1, 0, 1, 3'b000);
    @(negedge in_clk);
    chk("b2b_busy", {63'd0, out_busy}, 64'd1);
    issue(64'd0, 0, 1, 1, 3'b000);
    @(negedge in_clk);
    chk("b2b_busy2", {63'd0, out_busy}, 64'd1);
    wait_done("b2b", lat);
    chk("b2b_data", out_data, 64'h4014_0000_0000_0000);
    chk("b2b_nx", {63'd0, out_flag_NX}, 64'd0);
    @(negedge in_clk);
    chk("b2b_idle", {63'd0, out_valid | out_busy}, 64'd0);

    // Reset in the middle of normalisation
    issue(64'd1, 0, 1, 1, 3'b000);
    repeat (10) @(negedge in_clk);
    in_rst = 1'b1;
    @(posedge in_clk);
    #1 in_rst = 1'b0;
    @(negedge in_clk);
    chk("mrst_busy", {63'd0, out_busy}, 64'd0);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_data", out_data, 64'd0);
    chk("mrst_nx", {63'd0, out_flag_NX}, 64'd0);
    spurious = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge in_clk);
      if (out_valid) spurious++;
    end
    chk("mrst_no_valid", 64'(spurious), 64'd0);
    run("d_one", 64'd1, 0, 1, 1, 3'b000, 64'h3FF0_0000_0000_0000, 0, 66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_int_to_fp_seq.md
Name: fp_int_to_fp_seq

Overview:
- Multi-cycle integer-to-floating-point converter for the FP unit (FCVT.S.W/WU/L/LU, FCVT.D.W/WU/L/LU).
- It is the inverse path of the FP compare block: that block consumes FP operands and produces an integer result; this block consumes an integer operand and produces an FP result.
- Normalisation is sequential, one bit per cycle; rounding follows the RISC-V rounding modes.
- Sits beside the compare unit and shares the in_fmt convention: 0 = single, 1 = double.

Parameters:
- DATA_WIDTH, 64, operand and result width. Only 64 is supported.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge
- in_rst  input  1  synchronous, active-high reset
- in_valid  input  1  request strobe; accepted only when out_busy = 0
- in_data  input  DATA_WIDTH  integer operand
- in_signed  input  1  1 = two's-complement source, 0 = unsigned
- in_long  input  1  1 = 64-bit source; 0 = 32-bit source in in_data[31:0], upper bits ignored
- in_fmt  input  1  result format: 0 = single, 1 = double
- in_rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
- out_data  output  DATA_WIDTH  FP result; single results are NaN-boxed, upper 32 bits all ones
- out_valid  output  1  one-cycle pulse, out_data/out_flag_NX valid
- out_busy  output  1  high in NORM and ROUND
- out_flag_NX  output  1  inexact flag, valid with out_valid

Behaviour:
- Reset values: out_data = 0, out_valid = 0, out_busy = 0, out_flag_NX = 0; state = IDLE. Reset is synchronous and active-high.
- Reset asserted in any state returns to IDLE next edge and discards the operation in flight. No out_valid is produced for the discarded operation.
- States: IDLE, NORM, ROUND, DONE.

Accept:
- A request is accepted in IDLE or DONE when in_valid = 1. Requests during NORM or ROUND are ignored, not queued.
- On accept, all controls (in_signed, in_long, in_fmt, in_rm) are latched.
- Source value: if in_long = 0, in_data[31:0] is sign-extended (in_signed = 1) or zero-extended to 64 bits.
- Sign: sign = in_signed & src[63]. Magnitude mag = sign ? (~src + 1) : src, as 64-bit unsigned; -2^63 gives mag = 2^63.
- shift count is cleared to 0.
- If mag == 0: go directly to DONE with out_data = +0.0 (NaN-boxed for single) and NX = 0. Otherwise go to NORM.

NORM:
- If mag[63] = 1, go to ROUND.
- Otherwise mag <= mag << 1, count <= count + 1 (6-bit count, maximum 63), and stay in NORM.

ROUND:
- Unbiased exponent e = 63 - count; biased exponent = e + 127 (single) or e + 1023 (double).
- Double: mantissa = mag[62:11], guard = mag[10], sticky = |mag[9:0].
- Single: mantissa = mag[62:40], guard = mag[39], sticky = |mag[38:0].
- Round-up condition per mode:
  - RNE: guard & (sticky | mantissa LSB)
  - RTZ: never
  - RDN: sign & (guard | sticky)
  - RUP: !sign & (guard | sticky)
  - RMM: guard
- Mantissa increment carry-out clears the mantissa and adds 1 to the exponent.
- Overflow is impossible because 2^64 is below the single-precision maximum.
- NX = guard | sticky. Go to DONE.

DONE:
- out_valid = 1 for exactly this cycle.
- out_data and out_flag_NX hold their value until the next result is written.
- A new request may be accepted in DONE (back-to-back); otherwise the next state is IDLE.

Latency and busy:
- Latency from the accepting edge to out_valid high is 3 + count edges: 3 cycles minimum, 66 maximum. Zero input takes 1 edge.
- out_busy = 1 exactly in NORM and ROUND.

Test Plan:
- Double, in_signed = 1, in_long = 0, in_data = 32'hFFFFFFFF (-1), RNE -> out_data = 64'hBFF0000000000000, NX = 0, out_valid 66 cycles after accept.
- Double, signed, long, in_data = 64'h8000000000000000 -> 64'hC3E0000000000000, NX = 0, latency 3.
- Single, unsigned, long, in_data = 64'hFFFFFFFFFFFFFFFF:
  - RNE -> 64'hFFFFFFFF5F800000, NX = 1.
  - RTZ -> 64'hFFFFFFFF5F7FFFFF, NX = 1.
- Single, signed, 32-bit, in_data = 32'h01000001:
  - RNE -> 64'hFFFFFFFF4B800000 (tie to even), NX = 1.
  - RUP -> 64'hFFFFFFFF4B800001.
  - RDN -> 64'hFFFFFFFF4B800000.
- Zero input, double -> out_data = 0, NX = 0, out_valid one cycle after accept. Then a back-to-back request in DONE is accepted, and in_valid pulses during NORM are ignored while out_busy = 1.
- Assert in_rst during NORM of a 64-bit "1" conversion -> next cycle IDLE, all outputs 0, no out_valid. A subsequent request completes normally.
